ccff_bitstream_loader: RTL
==========================

Name: ccff_bitstream_loader

Overview:
Sequences programming of the FPGA fabric's configuration chain (CCFF) ahead of formal and random-stimulus verification runs. It accepts bitstream words over a valid/ready stream and shifts them serially, MSB first, into the chain head. Each shifted bit is qualified by a prog_en strobe. After exactly CHAIN_LEN bits it signals config_done, which releases the fabric to operating mode and gates the output-vector checker.

Parameters:
WORD_W, 8, width of each incoming bitstream word (>=1)
CHAIN_LEN, 20, total configuration bits in the chain (>=1)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin programming
abort  input  1  cancel programming; return to idle
in_data  input  WORD_W  bitstream word; MSB is shifted first
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a word this cycle
ccff_head  output  1  serial data to the chain head
prog_en  output  1  high on every cycle ccff_head carries a valid chain bit
busy  output  1  programming in progress
config_done  output  1  chain fully programmed (sticky)

Behaviour:
- Reset (async, any state): state=IDLE; shift register, bit counter and word-bit counter = 0. Outputs: in_ready=0, ccff_head=0, prog_en=0, busy=0, config_done=0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: start=1 -> LOAD; clear bit_cnt; clear config_done.
- LOAD: in_ready=1 (combinational from state); busy=1; prog_en=0.
  - in_valid & in_ready -> capture in_data into shift register, word_cnt=0, go to SHIFT.
  - in_valid=0 -> stay in LOAD; no bits emitted.
- SHIFT: prog_en=1; ccff_head=sreg[WORD_W-1]; sreg shifts left with zero fill; bit_cnt+1; word_cnt+1.
  - If bit_cnt==CHAIN_LEN-1 this cycle -> DONE. Remaining bits of the current word are discarded.
  - Else if word_cnt==WORD_W-1 -> LOAD.
  - Else stay in SHIFT.
- DONE: config_done=1, busy=0, prog_en=0, in_ready=0. Held until reset, abort, or start. start -> LOAD with config_done cleared and bit_cnt=0.
- Outside SHIFT: prog_en=0 and ccff_head=0.
- Latency: first chain bit appears the cycle after word acceptance. With in_valid held high, start at cycle 0 reaches DONE at cycle 1 + ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN.
- start while busy (LOAD/SHIFT): ignored.
- abort has priority over start and in_valid. In any state it goes to IDLE next cycle, clears config_done, and drops prog_en. Chain contents are undefined after abort.
- start and abort in the same cycle: abort wins.
- Counter widths:
  - bit_cnt: $clog2(CHAIN_LEN+1) bits; never wraps (DONE entered first).
  - word_cnt: $clog2(WORD_W) bits, minimum 1.
- CHAIN_LEN not a multiple of WORD_W: the final word is partially used, MSB side first.

Decomposition:
- Package ccff_loader_pkg: state enum (IDLE, LOAD, SHIFT, DONE), a width function for counters, and default WORD_W/CHAIN_LEN constants.
- One sub-module: ccff_piso. Parallel-load, shift-left register with load/shift enables and an MSB serial output. The FSM and counters remain in the top.

Test Plan:
- WORD_W=8, CHAIN_LEN=20; in_valid always high; words 0xA5, 0x3C, 0xF0 -> ccff_head under prog_en = 10100101 00111100 1111. Exactly 20 prog_en cycles, 3 words accepted, config_done rises at cycle 24.
- Stall: in_valid low for 5 cycles after the first word is consumed -> in_ready=1 and prog_en=0 throughout the stall. Bit sequence is unchanged; config_done is delayed by 5 cycles.
- Abort asserted on the 10th prog_en cycle -> IDLE next cycle; prog_en=0, busy=0, config_done=0. A fresh start then emits the full 20-bit sequence again.
- Async reset pulse mid-SHIFT (between clock edges) -> all outputs 0 immediately. start is ignored until reset deasserts.
- start pulsed during SHIFT -> no effect: the same 20 bits, and config_done at the same cycle as the baseline.
- Restart from DONE: start -> config_done falls the next cycle; a second bitstream 0xFF, 0x00, 0x0F -> 11111111 00000000 0000, then config_done=1.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the CCFF configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WORD_W    = 8;
  localparam int DEF_CHAIN_LEN = 20;

  // Bits needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in serial-out register: loads a word, shifts left with zero fill, MSB out.
module ccff_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams bitstream words MSB-first into the CCFF chain head and flags
// config_done once exactly CHAIN_LEN bits have been shifted.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              prog_en,
  output logic              busy,
  output logic              config_done
);

  localparam int BIT_W  = cnt_w(CHAIN_LEN + 1);
  localparam int WCNT_W = cnt_w(WORD_W);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic              load_word;
  logic              shift_bit;
  logic              sreg_msb;

  assign load_word = (state == LOAD) && in_valid && !abort;
  assign shift_bit = (state == SHIFT);

  ccff_piso #(
    .WIDTH (WORD_W)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load_word),
    .shift (shift_bit),
    .din   (in_data),
    .msb   (sreg_msb)
  );

  // abort outranks every other request, including start and in_valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            bit_cnt <= '0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            state    <= SHIFT;
            word_cnt <= '0;
          end
        end
        SHIFT: begin
          bit_cnt  <= bit_cnt + BIT_W'(1);
          word_cnt <= word_cnt + WCNT_W'(1);
          // chain end wins over word end, dropping any unused low bits
          if (bit_cnt == LAST_BIT) begin
            state <= DONE;
          end else if (word_cnt == LAST_WBIT) begin
            state <= LOAD;
          end
        end
        DONE: begin
          if (start) begin
            state   <= LOAD;
            bit_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode straight from the state register, so async reset clears them at once
  assign in_ready    = (state == LOAD);
  assign busy        = (state == LOAD) || (state == SHIFT);
  assign prog_en     = (state == SHIFT);
  assign ccff_head   = (state == SHIFT) && sreg_msb;
  assign config_done = (state == DONE);

endmodule
